// File: rtl/nios_hps_system_nios_leds.sv
// -----------------------------------------------------------------------------
// nios_hps_system_nios_leds
//
// Avalon-MM slave output port driving the board LEDs, with atomic set/clear
// access and a hardware blink engine.
//
// Register map (word address):
//   0 DATA     RW  base output value (WIDTH bits)
//   1 MASK     RW  bits inverted while the blink phase is 1
//   2 PERIOD   RW  blink half-period in clk cycles, 0 disables blinking
//   3 STATUS   RO  bit0 = blink phase
//   4 OUTSET   WO  DATA |= writedata
//   5 OUTCLEAR WO  DATA &= ~writedata
//   6,7            read as 0, writes ignored
//
// Ports:
//   clk        system clock
//   reset      synchronous active-high reset
//   address    register select
//   chipselect slave select
//   write_n    active-low write strobe, qualified by chipselect
//   writedata  write data
//   readdata   registered read data, 1-cycle latency, zero-extended
//   out_port   LED drive = DATA ^ (MASK & {WIDTH{phase}})
// -----------------------------------------------------------------------------
module nios_hps_system_nios_leds #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_MASK   = 3'd1;
    localparam logic [2:0] ADDR_PERIOD = 3'd2;
    localparam logic [2:0] ADDR_STATUS = 3'd3;
    localparam logic [2:0] ADDR_OUTSET = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR = 3'd5;

    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_mask;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_cnt;
    logic             r_phase;
    logic [31:0]      r_readdata;

    logic             w_wr;
    logic [WIDTH-1:0] w_wdata;
    logic [CNT_W-1:0] w_wperiod;
    logic [31:0]      w_rd_mux;
    logic             w_unused;

    assign w_wr      = chipselect & ~write_n;
    assign w_wdata   = writedata[WIDTH-1:0];
    assign w_wperiod = writedata[CNT_W-1:0];
    // Upper write-data bits are discarded by design.
    assign w_unused  = ^writedata;

    // Output register file: DATA and MASK.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data <= '0;
            r_mask <= '0;
        end else if (w_wr) begin
            case (address)
                ADDR_DATA:   r_data <= w_wdata;
                ADDR_MASK:   r_mask <= w_wdata;
                ADDR_OUTSET: r_data <= r_data | w_wdata;
                ADDR_OUTCLR: r_data <= r_data & ~w_wdata;
                default:     ;
            endcase
        end
    end

    // Blink engine. A PERIOD write restarts the cadence from phase 0 and takes
    // priority over a tick landing in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_period <= '0;
            r_cnt    <= '0;
            r_phase  <= 1'b0;
        end else if (w_wr && address == ADDR_PERIOD) begin
            r_period <= w_wperiod;
            r_cnt    <= (w_wperiod == '0) ? '0 : w_wperiod - CNT_W'(1);
            r_phase  <= 1'b0;
        end else if (r_period == '0) begin
            r_cnt    <= '0;
            r_phase  <= 1'b0;
        end else if (r_cnt == '0) begin
            r_cnt    <= r_period - CNT_W'(1);
            r_phase  <= ~r_phase;
        end else begin
            r_cnt    <= r_cnt - CNT_W'(1);
        end
    end

    // Read mux samples the registers before any same-cycle write lands.
    always_comb begin
        w_rd_mux = '0;
        case (address)
            ADDR_DATA:   w_rd_mux = 32'(r_data);
            ADDR_MASK:   w_rd_mux = 32'(r_mask);
            ADDR_PERIOD: w_rd_mux = 32'(r_period);
            ADDR_STATUS: w_rd_mux = {31'd0, r_phase};
            default:     w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= w_rd_mux;
        end
    end

    assign readdata = r_readdata;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_out
            assign out_port[gi] = r_data[gi] ^ (r_mask[gi] & r_phase);
        end
    endgenerate

endmodule

// File: doc/nios_hps_system_nios_leds.md
# nios_hps_system_nios_leds

Avalon-MM slave output port that drives the board LEDs from the Nios II / HPS bus, complementing the button input port on the same interconnect. It holds a software-written output value with atomic set/clear access and adds a hardware blink engine. A programmable down-counter toggles a phase bit that inverts selected output bits without CPU involvement. Readback uses the same registered, 1-cycle-latency scheme as the other PIO slaves.

## Interface
Parameters:
- WIDTH, 4, number of output bits (1..32)
- CNT_W, 24, width of blink period register/counter (1..31)

Ports:
- clk  in  1  system clock; the only clock
- reset  in  1  synchronous, active-high reset
- address  in  3  register select (word address)
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe, qualified by chipselect
- writedata  in  32  write data
- readdata  out  32  registered read data, zero-extended
- out_port  out  WIDTH  LED drive

## Operation
- Register map; a write is chipselect=1 and write_n=0:
  - 0 DATA: RW, WIDTH bits, base output value.
  - 1 MASK: RW, WIDTH bits, bits that blink.
  - 2 PERIOD: RW, CNT_W bits, blink half-period in clk cycles. 0 disables blinking.
  - 3 STATUS: RO, bit0 = phase, other bits 0. Writes are ignored.
  - 4 OUTSET: WO, DATA <= DATA | writedata[WIDTH-1:0]. Reads return 0.
  - 5 OUTCLEAR: WO, DATA <= DATA & ~writedata[WIDTH-1:0]. Reads return 0.
  - 6, 7: reads return 0; writes are ignored.
- out_port = DATA ^ (MASK & {WIDTH{phase}}), computed from registers only, with no write-data bypass.
- Blink engine, with counter cnt of CNT_W bits:
  - When PERIOD=0: cnt and phase are held at 0.
  - When PERIOD=P>0, each cycle: if cnt==0 then phase toggles and cnt <= P-1; otherwise cnt <= cnt-1.
  - A write to PERIOD loads cnt <= new P-1 (or 0 if P=0) and clears phase. In that cycle the write overrides the tick.
  - Writing DATA, MASK, OUTSET or OUTCLEAR does not disturb cnt or phase.
  - Tick and a DATA write in the same cycle: both take effect. out_port reflects the new DATA and the new phase on the next cycle.
- Writedata bits above WIDTH (or above CNT_W for PERIOD) are discarded. They read back as 0.
- readdata: every cycle, readdata <= zero-extended value selected by address, regardless of chipselect. There is no read strobe and reads have no side effects.
- Reset: DATA, MASK, PERIOD, cnt, phase and readdata are all 0, so out_port=0. Reset asserted mid-blink returns everything to 0 on the next edge. Bus writes during reset are ignored.

## Timing
- Write accepted on the rising edge where the strobe is valid. The new register value and out_port are visible from the following cycle.
- Read latency is 1 cycle: address presented at edge N gives data in readdata after edge N. Software/interconnect uses read latency 1 and zero wait states.
- Write followed immediately by a read of the same address returns the new value.
- With PERIOD=P written at edge t: phase first toggles at edge t+P, then every P edges after that. P=1 toggles every cycle.
- No internal stalls. All writes complete in one cycle.

## Test plan
- Reset with WIDTH=4: assert reset 2 cycles -> out_port=0. Readdata for addresses 0..5 = 0 after release.
- Write DATA=0xA, then OUTSET=0x1, then OUTCLEAR=0x8 -> out_port goes 0xA, 0xB, 0x3 on successive cycles. Reading addr 0 returns 0x3 with 1-cycle latency. Reading addr 4/5 returns 0.
- DATA=0x0, MASK=0x5, PERIOD=3 written at edge t:
  - out_port goes to 0x5 after edge t+3, back to 0x0 after t+6, and so on.
  - STATUS bit0 tracks phase.
- Mid-blink rewrite: with phase=1, write PERIOD=2 -> phase=0 next cycle, out_port=DATA, and the next toggle is 2 cycles after the write. Writing PERIOD=0 -> blinking stops with phase=0.
- Simultaneous tick and DATA write (PERIOD=1, MASK=0xF, write DATA=0x6) -> next cycle out_port = 0x6 ^ 0xF if the phase became 1, else 0x6. The counter keeps its cadence.
- Width masking: write 0xFFFFFFFF to DATA and to PERIOD with CNT_W=24 -> readback 0x0000000F and 0x00FFFFFF. Writes to addresses 3, 6, 7 change nothing.
